// File: rtl/alu_log_pkg.sv
// Shared opcodes and log-record layout for alu_log_buffer.
// ALU_OVF_EN adds a signed-overflow flag bit between carry and zero.
package alu_log_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;

`ifdef ALU_OVF_EN
  localparam int FLAG_W = 3;
`else
  localparam int FLAG_W = 2;
`endif

  // Record is {A, B, opcode, Y, c, [v], z} from MSB to LSB.
  function automatic int z_off();
    return 0;
  endfunction

`ifdef ALU_OVF_EN
  function automatic int v_off();
    return 1;
  endfunction
`endif

  function automatic int c_off();
    return FLAG_W - 1;
  endfunction

  function automatic int y_off();
    return FLAG_W;
  endfunction

  function automatic int op_off(input int width);
    return FLAG_W + width;
  endfunction

  function automatic int b_off(input int width);
    return FLAG_W + width + 3;
  endfunction

  function automatic int a_off(input int width);
    return FLAG_W + 2 * width + 3;
  endfunction

  function automatic int rec_w(input int width);
    return FLAG_W + 3 * width + 3;
  endfunction

endpackage

// File: rtl/alu_log_core.sv
// Combinational ALU feeding the log; carry is borrow for SUB.
// ALU_OVF_EN adds the signed-overflow output v_o.
module alu_log_core
  import alu_log_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] y_o,
  output logic             c_o
`ifdef ALU_OVF_EN
  ,
  output logic             v_o
`endif
);

  logic [WIDTH:0] sum;
  logic           shift_out;

  assign shift_out = ({1'b0, b_i} >= (WIDTH+1)'(WIDTH));

  always_comb begin
    sum = '0;
    y_o = '0;
    c_o = 1'b0;
    case (op_i)
      OP_ADD: begin
        sum = {1'b0, a_i} + {1'b0, b_i};
        y_o = sum[WIDTH-1:0];
        c_o = sum[WIDTH];
      end
      OP_SUB: begin
        y_o = a_i - b_i;
        c_o = (a_i < b_i);
      end
      OP_AND: y_o = a_i & b_i;
      OP_OR:  y_o = a_i | b_i;
      OP_NOT: y_o = ~a_i;
      OP_XOR: y_o = a_i ^ b_i;
      OP_SLL: y_o = shift_out ? '0 : (a_i << b_i);
      OP_SRL: y_o = shift_out ? '0 : (a_i >> b_i);
    endcase
  end

`ifdef ALU_OVF_EN
  always_comb begin
    v_o = 1'b0;
    if (op_i == OP_ADD)
      v_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (y_o[WIDTH-1] != a_i[WIDTH-1]);
    else if (op_i == OP_SUB)
      v_o = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (y_o[WIDTH-1] != a_i[WIDTH-1]);
  end
`endif

endmodule

// File: rtl/alu_log_buffer.sv
// Registered ALU whose results are appended to a DEPTH-entry log read by logical index.
// ALU_OVF_EN widens each record by a signed-overflow bit.
module alu_log_buffer
  import alu_log_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int WRAP  = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           A,
  input  logic [WIDTH-1:0]           B,
  input  logic [2:0]                 opcode,
  input  logic                       read_en,
  input  logic [$clog2(DEPTH)-1:0]   read_addr,
  output logic [rec_w(WIDTH)-1:0]    data_out,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH)-1:0]   maxfilled_addr,
  output logic                       full
);

  localparam int AW     = $clog2(DEPTH);
  localparam int REC_W  = rec_w(WIDTH);
  localparam int A_OFF  = a_off(WIDTH);
  localparam int B_OFF  = b_off(WIDTH);
  localparam int OP_OFF = op_off(WIDTH);
  localparam int Y_OFF  = y_off();
  localparam int C_OFF  = c_off();
  localparam int Z_OFF  = z_off();
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic [2:0]       s1_op_q;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    old_ptr_q, old_ptr_d;
  logic [AW:0]      count_q, count_d, count_m1;
  logic [AW-1:0]    maxfilled_q, maxfilled_d;
  logic             full_q;
  logic [REC_W-1:0] data_out_q;
  logic             rd_valid_q;

  logic [REC_W-1:0] mem [DEPTH];
  logic [REC_W-1:0] rec;
  logic [WIDTH-1:0] alu_y;
  logic             alu_c;
`ifdef ALU_OVF_EN
  logic             alu_v;
`endif

  logic [AW:0]      occ;
  logic             accept, full_now, wr_en, rd_hit;
  logic [AW-1:0]    rd_phys;

  alu_log_core #(.WIDTH(WIDTH)) u_core (
    .a_i  (s1_a_q),
    .b_i  (s1_b_q),
    .op_i (s1_op_q),
    .y_o  (alu_y),
    .c_o  (alu_c)
`ifdef ALU_OVF_EN
    ,
    .v_o  (alu_v)
`endif
  );

  // Stage-1 occupancy counts against capacity so a stalled log never drops an op.
  assign occ      = count_q + {{AW{1'b0}}, s1_valid_q};
  assign in_ready = !clear && ((WRAP != 0) || (occ < DEPTH_C));
  assign accept   = in_valid && in_ready;
  assign full_now = (count_q == DEPTH_C);
  assign wr_en    = s1_valid_q && !clear && ((WRAP != 0) || !full_now);
  assign rd_hit   = read_en && ({1'b0, read_addr} < count_q);
  assign rd_phys  = old_ptr_q + read_addr;

  always_comb begin
    rec = '0;
    rec[A_OFF +: WIDTH]  = s1_a_q;
    rec[B_OFF +: WIDTH]  = s1_b_q;
    rec[OP_OFF +: 3]     = s1_op_q;
    rec[Y_OFF +: WIDTH]  = alu_y;
    rec[C_OFF]           = alu_c;
`ifdef ALU_OVF_EN
    rec[v_off()]         = alu_v;
`endif
    rec[Z_OFF]           = (alu_y == '0);
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    old_ptr_d = old_ptr_q;
    count_d   = count_q;
    if (clear) begin
      wr_ptr_d  = '0;
      old_ptr_d = '0;
      count_d   = '0;
    end else if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (full_now) old_ptr_d = old_ptr_q + 1'b1;
      else          count_d   = count_q + 1'b1;
    end
    count_m1    = count_d - 1'b1;
    maxfilled_d = (count_d == '0) ? '0 : count_m1[AW-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= '0;
      wr_ptr_q    <= '0;
      old_ptr_q   <= '0;
      count_q     <= '0;
      maxfilled_q <= '0;
      full_q      <= 1'b0;
      data_out_q  <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_a_q  <= A;
        s1_b_q  <= B;
        s1_op_q <= opcode;
      end
      wr_ptr_q    <= wr_ptr_d;
      old_ptr_q   <= old_ptr_d;
      count_q     <= count_d;
      maxfilled_q <= maxfilled_d;
      full_q      <= (count_d == DEPTH_C);
      rd_valid_q  <= rd_hit;
      if (rd_hit) data_out_q <= mem[rd_phys];
    end
  end

  // Log storage has no reset; a same-edge write to the read entry returns the old record.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= rec;
  end

  assign data_out       = data_out_q;
  assign rd_valid       = rd_valid_q;
  assign count          = count_q;
  assign maxfilled_addr = maxfilled_q;
  assign full           = full_q;

endmodule
